// File: rtl/b_conv_encoder_213_pkg.sv
// Shared definitions for the (2,1,3) convolutional encoder: default code
// parameters, symbol width and the FSM state type.
package b_conv_encoder_213_pkg;

    // Encoder memory; the decoder's state count is 2**ENC_M.
    localparam int unsigned ENC_M       = 3;
    // Generators, bit M is the current-input tap (octal 13 and 17).
    localparam logic [3:0]  ENC_G0      = 4'b1011;
    localparam logic [3:0]  ENC_G1      = 4'b1111;
    // Append M zero tail bits per frame by default.
    localparam bit          ENC_TAIL_EN = 1'b1;
    // Code symbol width for a rate-1/2 code.
    localparam int unsigned SYM_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_t;

endpackage

// File: rtl/b_conv_encoder_213_if.sv
// Stream interface of the encoder: info-bit input side and code-symbol
// output side. master = the environment, slave = the encoder.
interface b_conv_encoder_213_if;
    import b_conv_encoder_213_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic             out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );

endinterface

// File: rtl/b_conv_encoder_213_parity.sv
// Combinational parity generator for the (2,1,3) code: maps the coding
// vector {u, sr} onto the symbol {c0, c1}. Pure XOR reductions.
module b_conv_parity_213
    import b_conv_encoder_213_pkg::*;
#(
    parameter int unsigned M  = ENC_M,
    parameter logic [M:0]  G0 = ENC_G0,
    parameter logic [M:0]  G1 = ENC_G1
) (
    input  logic [M:0]       v,
    output logic [SYM_W-1:0] sym
);

    // c0 from G0 lands on sym[1], c1 from G1 on sym[0].
    always_comb begin
        sym    = '0;
        sym[1] = ^(v & G0);
        sym[0] = ^(v & G1);
    end

endmodule

// File: rtl/b_conv_encoder_213.sv
// Frame-based (2,1,3) convolutional encoder. One info bit per input
// handshake produces one registered code symbol; M zero tail bits are
// appended per frame so the decoder can trace back from state 0.
module b_conv_encoder_213
    import b_conv_encoder_213_pkg::*;
#(
    parameter int unsigned M       = ENC_M,
    parameter logic [M:0]  G0      = ENC_G0,
    parameter logic [M:0]  G1      = ENC_G1,
    parameter bit          TAIL_EN = ENC_TAIL_EN
) (
    input  logic                  clock,
    input  logic                  reset,
    b_conv_encoder_213_if.slave   bus
);

    localparam int unsigned CW        = $clog2(M + 1);
    localparam logic [CW-1:0] TAIL_LAST = CW'(M - 1);

    enc_state_t       state_q,     state_d;
    logic [M-1:0]     sr_q,        sr_d;
    logic [CW-1:0]    tail_cnt_q,  tail_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [SYM_W-1:0] out_sym_q,   out_sym_d;
    logic             out_last_q,  out_last_d;

    logic             load_en;
    logic             in_ready;
    logic             accept;
    logic             tail_load;
    logic             do_load;
    logic             u;
    logic [SYM_W-1:0] code_sym;

    // Output register may load when empty or when its symbol leaves this cycle.
    always_comb begin
        load_en   = !out_valid_q || bus.out_ready;
        in_ready  = load_en && (state_q != ST_TAIL);
        accept    = bus.in_valid && in_ready;
        tail_load = load_en && (state_q == ST_TAIL);
        do_load   = accept || tail_load;
        u         = tail_load ? 1'b0 : bus.in_bit;
    end

    b_conv_parity_213 #(
        .M  (M),
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .v   ({u, sr_q}),
        .sym (code_sym)
    );

    // Next-state: output register, shift register, tail counter and FSM.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        // A free output slot with nothing to load becomes a bubble; the
        // held symbol stays in out_sym but is no longer valid.
        if (load_en) begin
            out_valid_d = do_load;
            out_last_d  = 1'b0;
            if (do_load) begin
                out_sym_d = code_sym;
                sr_d      = {u, sr_q[M-1:1]};
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    if (bus.in_last) begin
                        if (TAIL_EN) begin
                            state_d    = ST_TAIL;
                            tail_cnt_d = '0;
                        end else begin
                            // No tail: flag this data symbol as last and
                            // force the trellis back to state 0.
                            state_d    = ST_IDLE;
                            out_last_d = 1'b1;
                            sr_d       = '0;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_TAIL: begin
                if (tail_load) begin
                    if (tail_cnt_q == TAIL_LAST) begin
                        state_d    = ST_IDLE;
                        out_last_d = 1'b1;
                        sr_d       = '0;
                        tail_cnt_d = '0;
                    end else begin
                        tail_cnt_d = tail_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                sr_d       = '0;
                tail_cnt_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_b_conv_encoder_213.sv
// Self-checking bench for b_conv_encoder_213: directed frames with known
// code sequences plus random frames against a tap-level reference model.
module tb_b_conv_encoder_213;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    b_conv_encoder_213_if bus ();

    b_conv_encoder_213 #(
        .M       (3),
        .G0      (4'b1011),
        .G1      (4'b1111),
        .TAIL_EN (1'b1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc   = 0;
    logic [2:0]  exp_q [$];   // {out_sym, out_last}
    logic [2:0]  obs_q [$];
    int          obs_cyc [$];
    bit          rdy_rand   = 1'b0;
    logic        rdy_manual = 1'b1;

    // Single driver of out_ready, applied 2 ns after each rising edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        #2;
        bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_manual;
    end

    // Record every symbol that will be accepted at the next rising edge.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            obs_q.push_back({bus.out_sym, bus.out_last});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: c0 = u(t)^u(t-2)^u(t-3), c1 = u(t)^u(t-1)^u(t-2)^u(t-3).
    function automatic logic ubit(input logic bits [$], input int k);
        if (k < 0 || k >= bits.size()) return 1'b0;
        return bits[k];
    endfunction

    task automatic push_frame(input logic bits [$]);
        int n = bits.size();
        for (int t = 0; t < n + 3; t++) begin
            logic c0, c1;
            c0 = ubit(bits, t) ^ ubit(bits, t - 2) ^ ubit(bits, t - 3);
            c1 = ubit(bits, t) ^ ubit(bits, t - 1) ^ ubit(bits, t - 2) ^ ubit(bits, t - 3);
            exp_q.push_back({c0, c1, 1'(t == n + 2)});
        end
    endtask

    // Present one bit and hold it until accepted; returns at edge+1ns.
    task automatic drive_bit(input logic b, input logic last, output bit ok);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = last;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
        end
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        n_chk++;
        if (bus.out_sym !== 2'b00 || bus.out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_sym got=%b/%b want=00/0", bus.out_sym, bus.out_last);
        end
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_impulse();
        bit ok;
        clear_q();
        rdy_manual = 1'b1;
        exp_q = '{3'b110, 3'b010, 3'b110, 3'b111};
        drive_bit(1'b1, 1'b1, ok);
        n_chk++;
        if (!ok) begin n_err++; $display("FAIL impulse_accept got=timeout want=accepted"); end
        wait_obs(exp_q.size(), ok);
        n_chk++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL impulse_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL impulse_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL impulse_idle_valid got=%b want=0", bus.out_valid);
        end
    endtask

    task automatic test_two_bits();
        bit ok0, ok1, okw;
        int zeros = 0;
        clear_q();
        rdy_manual = 1'b1;
        exp_q = '{3'b110, 3'b100, 3'b100, 3'b000, 3'b111};
        drive_bit(1'b1, 1'b0, ok0);
        drive_bit(1'b1, 1'b1, ok1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (bus.in_ready === 1'b0) zeros++;
        end
        @(negedge clock);
        n_chk++;
        if (zeros != 3 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL two_bits_tail_ready got=%0d_low_then_%b want=3_low_then_1", zeros, bus.in_ready);
        end
        wait_obs(exp_q.size(), okw);
        n_chk++;
        if (!ok0 || !ok1 || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL two_bits_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL two_bits_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok0, ok1, okw;
        int held = 0;
        clear_q();
        rdy_manual = 1'b1;
        exp_q = '{3'b110, 3'b100, 3'b100, 3'b000, 3'b111};
        drive_bit(1'b1, 1'b0, ok0);
        drive_bit(1'b1, 1'b1, ok1);
        rdy_manual = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus.out_valid === 1'b1 && bus.out_sym === 2'b10 && bus.in_ready === 1'b0)
                held++;
        end
        rdy_manual = 1'b1;
        n_chk++;
        if (held != 5) begin
            n_err++;
            $display("FAIL backpressure_hold got=%0d want=5 cycles", held);
        end
        wait_obs(exp_q.size(), okw);
        n_chk++;
        if (!ok0 || !ok1 || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL backpressure_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL backpressure_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, ok2, okw;
        clear_q();
        rdy_manual = 1'b1;
        exp_q = '{3'b110, 3'b010, 3'b110, 3'b111,
                  3'b000, 3'b110, 3'b010, 3'b110, 3'b111};
        drive_bit(1'b1, 1'b1, ok0);
        drive_bit(1'b0, 1'b0, ok1);
        drive_bit(1'b1, 1'b1, ok2);
        wait_obs(exp_q.size(), okw);
        n_chk++;
        if (!ok0 || !ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
        n_chk++;
        if (obs_cyc.size() == 9 && (obs_cyc[8] - obs_cyc[0]) != 8) begin
            n_err++;
            $display("FAIL b2b_no_gap got=%0d cycles want=8", obs_cyc[8] - obs_cyc[0]);
        end
    endtask

    task automatic test_reset_mid_tail();
        bit ok0, ok1, okw;
        logic [2:0] pre [$];
        clear_q();
        rdy_manual = 1'b1;
        pre = '{3'b110, 3'b100};
        drive_bit(1'b1, 1'b0, ok0);
        drive_bit(1'b1, 1'b1, ok1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_handshake got=valid%b_ready%b want=valid0_ready1", bus.out_valid, bus.in_ready);
        end
        n_chk++;
        if (!ok0 || !ok1 || obs_q.size() != 2 || obs_q[0] !== pre[0] || obs_q[1] !== pre[1]) begin
            n_err++;
            $display("FAIL midreset_pre got=%0d symbols want=2 (110,100)", obs_q.size());
        end
        @(posedge clock);
        #1;
        clear_q();
        exp_q = '{3'b110, 3'b010, 3'b110, 3'b111};
        drive_bit(1'b1, 1'b1, ok0);
        wait_obs(exp_q.size(), okw);
        n_chk++;
        if (!ok0 || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midreset_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL midreset_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok, all_ok;
        logic bits [$];
        int n;
        clear_q();
        rdy_rand = 1'b1;
        all_ok = 1'b1;
        for (int f = 0; f < 4; f++) begin
            n = (f == 1) ? 1000 : $urandom_range(1, 30);
            bits.delete();
            for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
            push_frame(bits);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    @(posedge clock);
                    #1;
                end
                drive_bit(bits[i], 1'(i == n - 1), ok);
                if (!ok) all_ok = 1'b0;
            end
        end
        wait_obs(exp_q.size(), ok);
        rdy_rand = 1'b0;
        n_chk++;
        if (!all_ok || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [2:0] got = (i < obs_q.size()) ? obs_q[i] : 3'bxxx;
            n_chk++;
            if (got !== exp_q[i]) begin
                n_err++;
                $display("FAIL random_sym[%0d] got=%b want=%b", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_two_bits();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_tail();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
